// File: rtl/ahb_master_if.sv
// AHB-Lite master front end: turns a single command (address, burst, size, direction)
// into a pipelined AHB transfer sequence, with wrap/1KB handling and two-cycle ERROR abort.
`timescale 1ns/1ps
module ahb_master_if #(
   parameter int unsigned AHB_DATA_WIDTH = 32,
   parameter int unsigned AHB_ADDR_WIDTH = 32
) (
   input  logic                      ahb_clk_in,
   input  logic                      ahb_rst_in,
   input  logic                      other_start_in,
   input  logic [AHB_ADDR_WIDTH-1:0] other_addr_in,
   input  logic [2:0]                other_burst_in,
   input  logic [4:0]                other_len_in,
   input  logic [2:0]                other_size_in,
   input  logic                      other_write_in,
   input  logic [AHB_DATA_WIDTH-1:0] other_wdata_in,
   output logic                      other_wnext_out,
   output logic [AHB_DATA_WIDTH-1:0] other_rdata_out,
   output logic                      other_rvalid_out,
   output logic                      other_busy_out,
   output logic                      other_done_out,
   output logic                      other_error_out,
   output logic [AHB_ADDR_WIDTH-1:0] ahb_addr_out,
   output logic [2:0]                ahb_burst_out,
   output logic [2:0]                ahb_size_out,
   output logic [1:0]                ahb_trans_out,
   output logic                      ahb_write_out,
   output logic [AHB_DATA_WIDTH-1:0] ahb_wdata_out,
   input  logic [AHB_DATA_WIDTH-1:0] ahb_rdata_in,
   input  logic                      ahb_ready_in,
   input  logic                      ahb_resp_in
);

   localparam logic [1:0] TransIdle   = 2'd0;
   localparam logic [1:0] TransNonseq = 2'd2;
   localparam logic [1:0] TransSeq    = 2'd3;
   localparam logic [2:0] BurstIncr   = 3'd1;

   typedef enum logic [2:0] {StIdle, StAddr, StData, StErr1, StErr2} state_e;

   state_e                    state_q, state_d;
   logic [AHB_ADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic [2:0]                hburst_q, hburst_d;
   logic [2:0]                hsize_q, hsize_d;
   logic [1:0]                htrans_q, htrans_d;
   logic                      hwrite_q, hwrite_d;
   logic [AHB_DATA_WIDTH-1:0] hwdata_q, hwdata_d;
   logic [AHB_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [3:0]                addr_left_q, addr_left_d;
   logic                      dphase_q, dphase_d;
   logic                      rvalid_q, rvalid_d;
   logic                      done_q, done_d;
   logic                      error_q, error_d;

   logic                      cmd_ok;
   logic [3:0]                last_beat;
   logic [AHB_ADDR_WIDTH-1:0] align_mask;
   logic [AHB_ADDR_WIDTH-1:0] step, incr_addr, wrap_bytes, wrap_mask, next_addr;
   logic                      is_wrap, cross_1k, err_start, addr_done;

   // Command legality and beat count, decoded straight from the request inputs
   always_comb begin
      align_mask = (AHB_ADDR_WIDTH'(1) << other_size_in) - AHB_ADDR_WIDTH'(1);
      cmd_ok     = ((32'd8 << other_size_in) <= AHB_DATA_WIDTH) &&
                   ((other_addr_in & align_mask) == '0);
      unique case (other_burst_in)
         3'd0:       last_beat = 4'd0;
         3'd1: begin
            if (other_len_in == 5'd0)       last_beat = 4'd0;
            else if (other_len_in > 5'd16)  last_beat = 4'd15;
            else                            last_beat = 4'(other_len_in - 5'd1);
         end
         3'd2, 3'd3: last_beat = 4'd3;
         3'd4, 3'd5: last_beat = 4'd7;
         default:    last_beat = 4'd15;
      endcase
   end

   // Next beat address: wrap inside the aligned block, otherwise plain increment
   always_comb begin
      step      = AHB_ADDR_WIDTH'(1) << hsize_q;
      incr_addr = haddr_q + step;
      is_wrap   = (hburst_q != 3'd0) && !hburst_q[0];
      unique case (hburst_q)
         3'd2:    wrap_bytes = AHB_ADDR_WIDTH'(4) << hsize_q;
         3'd4:    wrap_bytes = AHB_ADDR_WIDTH'(8) << hsize_q;
         3'd6:    wrap_bytes = AHB_ADDR_WIDTH'(16) << hsize_q;
         default: wrap_bytes = '0;
      endcase
      wrap_mask = wrap_bytes - AHB_ADDR_WIDTH'(1);
      next_addr = is_wrap ? ((haddr_q & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
      cross_1k  = !is_wrap && (next_addr[AHB_ADDR_WIDTH-1:10] != haddr_q[AHB_ADDR_WIDTH-1:10]);
   end

   // First ERROR cycle can only be seen while a data phase is outstanding
   assign err_start = ahb_resp_in && !ahb_ready_in &&
                      ((state_q == StAddr && dphase_q) || state_q == StData);
   assign addr_done = (state_q == StAddr) && ahb_ready_in && !err_start;

   // State register
   always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
      if (ahb_rst_in) state_q <= StIdle;
      else            state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (other_start_in && cmd_ok) state_d = StAddr;
         StAddr: begin
            if (err_start)                                  state_d = StErr1;
            else if (ahb_ready_in && addr_left_q == 4'd0)   state_d = StData;
         end
         StData: begin
            if (err_start)         state_d = StErr1;
            else if (ahb_ready_in) state_d = StIdle;
         end
         StErr1: if (ahb_ready_in) state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      other_busy_out  = (state_q != StIdle);
      other_wnext_out = addr_done && hwrite_q;
   end

   // Bus and handshake register updates
   always_comb begin
      haddr_d     = haddr_q;
      hburst_d    = hburst_q;
      hsize_d     = hsize_q;
      htrans_d    = htrans_q;
      hwrite_d    = hwrite_q;
      hwdata_d    = hwdata_q;
      rdata_d     = rdata_q;
      addr_left_d = addr_left_q;
      dphase_d    = dphase_q;
      rvalid_d    = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (other_start_in) begin
               if (cmd_ok) begin
                  haddr_d     = other_addr_in;
                  hburst_d    = other_burst_in;
                  hsize_d     = other_size_in;
                  hwrite_d    = other_write_in;
                  htrans_d    = TransNonseq;
                  addr_left_d = last_beat;
                  dphase_d    = 1'b0;
               end else begin
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end
            end
         end
         StAddr: begin
            if (err_start) begin
               htrans_d = TransIdle;
            end else if (ahb_ready_in) begin
               dphase_d = 1'b1;
               if (hwrite_q) hwdata_d = other_wdata_in;
               if (dphase_q && !hwrite_q && !ahb_resp_in) begin
                  rdata_d  = ahb_rdata_in;
                  rvalid_d = 1'b1;
               end
               if (addr_left_q == 4'd0) begin
                  htrans_d = TransIdle;
               end else begin
                  addr_left_d = addr_left_q - 4'd1;
                  haddr_d     = next_addr;
                  htrans_d    = cross_1k ? TransNonseq : TransSeq;
                  if (cross_1k) hburst_d = BurstIncr;
               end
            end
         end
         StData: begin
            if (!err_start && ahb_ready_in) begin
               if (!hwrite_q && !ahb_resp_in) begin
                  rdata_d  = ahb_rdata_in;
                  rvalid_d = 1'b1;
               end
               done_d  = 1'b1;
               error_d = ahb_resp_in;
            end
         end
         StErr2: begin
            done_d  = 1'b1;
            error_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers, all cleared by reset so an in-flight command is simply dropped
   always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
      if (ahb_rst_in) begin
         haddr_q     <= '0;
         hburst_q    <= '0;
         hsize_q     <= '0;
         htrans_q    <= TransIdle;
         hwrite_q    <= 1'b0;
         hwdata_q    <= '0;
         rdata_q     <= '0;
         addr_left_q <= '0;
         dphase_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         haddr_q     <= haddr_d;
         hburst_q    <= hburst_d;
         hsize_q     <= hsize_d;
         htrans_q    <= htrans_d;
         hwrite_q    <= hwrite_d;
         hwdata_q    <= hwdata_d;
         rdata_q     <= rdata_d;
         addr_left_q <= addr_left_d;
         dphase_q    <= dphase_d;
         rvalid_q    <= rvalid_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign ahb_addr_out     = haddr_q;
   assign ahb_burst_out    = hburst_q;
   assign ahb_size_out     = hsize_q;
   assign ahb_trans_out    = htrans_q;
   assign ahb_write_out    = hwrite_q;
   assign ahb_wdata_out    = hwdata_q;
   assign other_rdata_out  = rdata_q;
   assign other_rvalid_out = rvalid_q;
   assign other_done_out   = done_q;
   assign other_error_out  = error_q;

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if: the bench plays the AHB slave cycle by cycle.
`timescale 1ns/1ps
module tb_ahb_master_if;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] addr;
   logic [2:0]    burst;
   logic [4:0]    len;
   logic [2:0]    size;
   logic          write;
   logic [DW-1:0] wdata;
   logic          wnext;
   logic [DW-1:0] rdata_out;
   logic          rvalid;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW-1:0] haddr;
   logic [2:0]    hburst;
   logic [2:0]    hsize;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [DW-1:0] hwdata;
   logic [DW-1:0] hrdata;
   logic          hready;
   logic          hresp;

   int checks = 0;
   int errors = 0;
   int rv_cnt;

   always #5 clk = ~clk;

   ahb_master_if #(.AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW)) dut (
      .ahb_clk_in       (clk),
      .ahb_rst_in       (rst),
      .other_start_in   (start),
      .other_addr_in    (addr),
      .other_burst_in   (burst),
      .other_len_in     (len),
      .other_size_in    (size),
      .other_write_in   (write),
      .other_wdata_in   (wdata),
      .other_wnext_out  (wnext),
      .other_rdata_out  (rdata_out),
      .other_rvalid_out (rvalid),
      .other_busy_out   (busy),
      .other_done_out   (done),
      .other_error_out  (error),
      .ahb_addr_out     (haddr),
      .ahb_burst_out    (hburst),
      .ahb_size_out     (hsize),
      .ahb_trans_out    (htrans),
      .ahb_write_out    (hwrite),
      .ahb_wdata_out    (hwdata),
      .ahb_rdata_in     (hrdata),
      .ahb_ready_in     (hready),
      .ahb_resp_in      (hresp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; addr = '0; burst = '0; len = '0; size = '0;
      write = 1'b0; wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;

      // Reset state
      next(); next(); #1;
      chk("rst_trans", htrans, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_addr", haddr, 32'h0);
      next(); rst = 1'b0;

      // SINGLE write 0x100, size 2
      next(); start = 1'b1; addr = 32'h100; burst = 3'd0; size = 3'd2; write = 1'b1;
      wdata = 32'hDEADBEEF; #1;
      chk("single_idle_busy", busy, 1'b0);
      next(); start = 1'b0; #1;
      chk("single_trans", htrans, 2'd2);
      chk("single_addr", haddr, 32'h100);
      chk("single_write", hwrite, 1'b1);
      chk("single_size", hsize, 3'd2);
      chk("single_wnext", wnext, 1'b1);
      chk("single_busy", busy, 1'b1);
      next(); wdata = 32'h0; #1;
      chk("single_dphase_trans", htrans, 2'd0);
      chk("single_wdata", hwdata, 32'hDEADBEEF);
      chk("single_wnext_off", wnext, 1'b0);
      chk("single_done_early", done, 1'b0);
      next(); #1;
      chk("single_done", done, 1'b1);
      chk("single_error", error, 1'b0);
      chk("single_busy_end", busy, 1'b0);
      next(); #1;
      chk("single_done_pulse", done, 1'b0);

      // WRAP4 read 0x38, size 2; a start while busy must be ignored
      next(); start = 1'b1; addr = 32'h38; burst = 3'd2; size = 3'd2; write = 1'b0; #1;
      next(); start = 1'b0; #1;
      chk("wrap_a1", haddr, 32'h38);
      chk("wrap_t1", htrans, 2'd2);
      chk("wrap_burst", hburst, 3'd2);
      chk("wrap_wnext", wnext, 1'b0);
      next(); hrdata = 32'h11; start = 1'b1; addr = 32'h500; #1;
      chk("wrap_a2", haddr, 32'h3C);
      chk("wrap_t2", htrans, 2'd3);
      chk("wrap_rv2", rvalid, 1'b0);
      next(); hrdata = 32'h22; start = 1'b0; #1;
      chk("wrap_a3", haddr, 32'h30);
      chk("wrap_t3", htrans, 2'd3);
      chk("wrap_rv_a", rvalid, 1'b1);
      chk("wrap_rd_a", rdata_out, 32'h11);
      next(); hrdata = 32'h33; #1;
      chk("wrap_a4", haddr, 32'h34);
      chk("wrap_t4", htrans, 2'd3);
      chk("wrap_rd_b", rdata_out, 32'h22);
      next(); hrdata = 32'h44; #1;
      chk("wrap_t_data", htrans, 2'd0);
      chk("wrap_rd_c", rdata_out, 32'h33);
      next(); #1;
      chk("wrap_rv_d", rvalid, 1'b1);
      chk("wrap_rd_d", rdata_out, 32'h44);
      chk("wrap_done", done, 1'b1);

      // INCR len 4 write across the 1 KB boundary
      next(); start = 1'b1; addr = 32'h3F8; burst = 3'd1; len = 5'd4; size = 3'd2;
      write = 1'b1; wdata = 32'hA0; #1;
      next(); start = 1'b0; #1;
      chk("incr_a1", haddr, 32'h3F8);
      chk("incr_t1", htrans, 2'd2);
      chk("incr_burst", hburst, 3'd1);
      next(); wdata = 32'hA1; #1;
      chk("incr_a2", haddr, 32'h3FC);
      chk("incr_t2", htrans, 2'd3);
      chk("incr_wd1", hwdata, 32'hA0);
      next(); wdata = 32'hA2; #1;
      chk("incr_a3", haddr, 32'h400);
      chk("incr_t3", htrans, 2'd2);
      chk("incr_wd2", hwdata, 32'hA1);
      next(); wdata = 32'hA3; #1;
      chk("incr_a4", haddr, 32'h404);
      chk("incr_t4", htrans, 2'd3);
      next(); #1;
      chk("incr_wd4", hwdata, 32'hA3);
      next(); #1;
      chk("incr_done", done, 1'b1);

      // INCR8 read at 0x0 with three wait states on beat 3
      next(); start = 1'b1; addr = 32'h0; burst = 3'd5; size = 3'd2; write = 1'b0; #1;
      rv_cnt = 0;
      for (int i = 1; i <= 13; i++) begin
         next();
         start  = 1'b0;
         hready = !(i >= 4 && i <= 6);
         if (i == 2)                 hrdata = 32'd1;
         else if (i == 3)            hrdata = 32'd2;
         else if (i >= 7 && i <= 12) hrdata = 32'(i - 4);
         else                        hrdata = 32'hFF;
         #1;
         if (i == 1)       chk("incr8_trans", htrans, 2'd2);
         else if (i <= 11) chk("incr8_trans", htrans, 2'd3);
         else              chk("incr8_trans", htrans, 2'd0);
         if (i <= 3)       chk("incr8_addr", haddr, 32'((i - 1) * 4));
         else if (i <= 7)  chk("incr8_addr_hold", haddr, 32'hC);
         else if (i <= 11) chk("incr8_addr", haddr, 32'((i - 4) * 4));
         if (rvalid) begin
            rv_cnt++;
            chk("incr8_rdata", rdata_out, 64'(rv_cnt));
         end
         if (i == 13) chk("incr8_done", done, 1'b1);
      end
      chk("incr8_rv_count", 64'(rv_cnt), 64'd8);
      hready = 1'b1;

      // INCR4 read with two-cycle ERROR on beat 2
      next(); start = 1'b1; addr = 32'h200; burst = 3'd3; size = 3'd2; write = 1'b0; #1;
      next(); start = 1'b0; #1;
      chk("err_a1", haddr, 32'h200);
      next(); hrdata = 32'h55; #1;
      chk("err_a2", haddr, 32'h204);
      next(); hready = 1'b0; hresp = 1'b1; #1;
      chk("err_a3", haddr, 32'h208);
      chk("err_rv1", rvalid, 1'b1);
      chk("err_rd1", rdata_out, 32'h55);
      next(); hready = 1'b1; hresp = 1'b1; #1;
      chk("err1_trans", htrans, 2'd0);
      chk("err1_busy", busy, 1'b1);
      next(); hresp = 1'b0; #1;
      chk("err2_trans", htrans, 2'd0);
      chk("err2_done", done, 1'b0);
      next(); #1;
      chk("err_done", done, 1'b1);
      chk("err_error", error, 1'b1);
      chk("err_busy", busy, 1'b0);
      chk("err_trans", htrans, 2'd0);
      chk("err_rv", rvalid, 1'b0);
      next(); #1;
      chk("err_done_pulse", done, 1'b0);
      chk("err_error_pulse", error, 1'b0);

      // Illegal commands: oversize, then misaligned
      next(); start = 1'b1; addr = 32'h100; burst = 3'd0; size = 3'd3; write = 1'b1; #1;
      next(); start = 1'b0; #1;
      chk("size_done", done, 1'b1);
      chk("size_error", error, 1'b1);
      chk("size_trans", htrans, 2'd0);
      chk("size_busy", busy, 1'b0);
      next(); start = 1'b1; addr = 32'h102; size = 3'd2; #1;
      chk("align_pre_trans", htrans, 2'd0);
      next(); start = 1'b0; #1;
      chk("align_done", done, 1'b1);
      chk("align_error", error, 1'b1);
      chk("align_trans", htrans, 2'd0);
      next(); #1;
      chk("align_done_pulse", done, 1'b0);

      // Reset mid-burst
      next(); start = 1'b1; addr = 32'h300; burst = 3'd3; size = 3'd2; write = 1'b1;
      wdata = 32'h77; #1;
      next(); start = 1'b0; #1;
      chk("rstb_t1", htrans, 2'd2);
      next(); #1;
      chk("rstb_a2", haddr, 32'h304);
      rst = 1'b1; #1;
      chk("rstb_trans", htrans, 2'd0);
      chk("rstb_addr", haddr, 32'h0);
      chk("rstb_write", hwrite, 1'b0);
      chk("rstb_wdata", hwdata, 32'h0);
      chk("rstb_burst", hburst, 3'd0);
      chk("rstb_size", hsize, 3'd0);
      chk("rstb_busy", busy, 1'b0);
      chk("rstb_wnext", wnext, 1'b0);
      next(); rst = 1'b0; #1;
      next(); #1;
      chk("rstb_no_done", done, 1'b0);
      chk("rstb_idle", htrans, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
